// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared N-to-1 mux.
// Grants are held while requested, up to MAX_HOLD cycles when others wait.
module mux_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy,
  output logic                 preempt
);

  localparam int unsigned SW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state, state_n;
  logic [SW-1:0] ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] sel_n;
  logic [N-1:0]  gnt_n;
  logic          busy_n;
  logic          preempt_n;

  logic [N-1:0]  owner_oh;
  logic [N-1:0]  others;
  logic [SW-1:0] next_ptr;

  // First set bit of r scanning start, start+1, ... with modulo-N wrap
  function automatic logic [SW-1:0] pick(input logic [N-1:0] r, input logic [SW-1:0] start);
    logic [SW-1:0] res;
    logic [SW-1:0] idx;
    res = start;
    for (int i = N - 1; i >= 0; i--) begin
      idx = start + SW'(i);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  assign owner_oh = N'(1) << sel;
  assign others   = req & ~owner_oh;
  assign next_ptr = sel + SW'(1);

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    sel_n     = sel;
    busy_n    = busy;
    preempt_n = 1'b0;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (|req) begin
          sel_n   = pick(req, ptr);
          busy_n  = 1'b1;
          cnt_n   = CW'(1);
          state_n = GRANT;
        end
      end

      GRANT: begin
        if (!req[sel]) begin
          ptr_n = next_ptr;
          if (|others) begin
            sel_n = pick(others, next_ptr);
            cnt_n = CW'(1);
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else if (cnt == HOLD_MAX) begin
          // Timeout only rotates if someone else is waiting; otherwise cnt saturates
          if (|others) begin
            ptr_n     = next_ptr;
            sel_n     = pick(others, next_ptr);
            cnt_n     = CW'(1);
            preempt_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase

    gnt_n = busy_n ? (N'(1) << sel_n) : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      sel     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      sel     <= sel_n;
      gnt     <= gnt_n;
      busy    <= busy_n;
      preempt <= preempt_n;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N=4, MAX_HOLD=8) with a shared 4-to-1 mux.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  logic [3:0] data;
  logic       y;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  assign data = 4'b0101;
  assign y    = data[sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Active grant to requester w, including the mux output it implies
  task automatic chk_grant(input string tag, input int w);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    chk({tag, " gnt"},  32'(gnt),  32'(oh));
    chk({tag, " sel"},  32'(sel),  32'(w));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " y"},    32'(y),    (w % 2 == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_idle(input string tag, input int s);
    chk({tag, " gnt"},     32'(gnt),     32'd0);
    chk({tag, " sel"},     32'(sel),     32'(s));
    chk({tag, " busy"},    32'(busy),    32'd0);
    chk({tag, " preempt"}, 32'(preempt), 32'd0);
  endtask

  initial begin
    // T1: reset held with all requesting, then first grant one edge after release
    reset = 1'b1;
    req   = 4'b1111;
    step();
    step();
    chk_idle("T1 reset", 0);
    reset = 1'b0;
    step();

    // T2: full contention, 8 cycles per owner in order 0,1,2,3,0
    for (int c = 0; c < 40; c++) begin
      chk_grant($sformatf("T2 c%0d", c), (c / 8) % 4);
      chk($sformatf("T2 c%0d preempt", c), 32'(preempt),
          ((c % 8 == 0) && (c > 0)) ? 32'd1 : 32'd0);
      step();
    end
    chk_grant("T2 wrap", 1);
    chk("T2 wrap preempt", 32'(preempt), 32'd1);

    // T3: lone requester 2 holds past MAX_HOLD without preemption
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_grant($sformatf("T3 c%0d", c), 2);
      chk($sformatf("T3 c%0d preempt", c), 32'(preempt), 32'd0);
    end

    // T4: owner 1 releases while 3 waits, then everyone drops
    req = 4'b0010;
    step();
    chk_grant("T4 own1", 1);
    req = 4'b1010;
    step();
    chk_grant("T4 hold1", 1);
    req = 4'b1000;
    step();
    chk_grant("T4 to3", 3);
    chk("T4 to3 preempt", 32'(preempt), 32'd0);
    req = 4'b0000;
    step();
    chk_idle("T4 idle", 3);
    step();
    chk_idle("T4 idle2", 3);

    // T5: owner 1 releases to IDLE (ptr=2), so 3 beats 0
    req = 4'b0010;
    step();
    chk_grant("T5 own1", 1);
    req = 4'b0000;
    step();
    chk_idle("T5 idle", 1);
    req = 4'b1001;
    step();
    chk_grant("T5 first3", 3);
    req = 4'b0001;
    step();
    chk_grant("T5 then0", 0);
    chk("T5 then0 preempt", 32'(preempt), 32'd0);

    // T6: reset during owner 2's 4th cycle
    req = 4'b0100;
    step();
    chk_grant("T6 own2 c1", 2);
    step();
    step();
    step();
    chk_grant("T6 own2 c4", 2);
    reset = 1'b1;
    step();
    chk_idle("T6 reset", 0);
    reset = 1'b0;
    req   = 4'b1111;
    step();
    chk_grant("T6 regrant", 0);
    chk("T6 regrant preempt", 32'(preempt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
